// File: rtl/bsg_manycore_vcache_wh_mem_pkg.sv
`default_nettype none
// ======================================================================
// Package : bsg_manycore_vcache_wh_mem_pkg
// Shared header layout, FSM states and limits for the vcache wh endpoint.
// Rev     : 1.0
// ======================================================================

// Header flit layout, LSB first: dest, len, cid, write_not_read, src, pad.
`define DECLARE_BSG_VCACHE_WH_MEM_HDR_S(flit_width_mp, cord_width_mp, len_width_mp, cid_width_mp) \
  typedef struct packed { \
    logic [flit_width_mp-2*cord_width_mp-len_width_mp-cid_width_mp-2:0] pad; \
    logic [cord_width_mp-1:0]                                           src_cord; \
    logic                                                               write_not_read; \
    logic [cid_width_mp-1:0]                                            cid; \
    logic [len_width_mp-1:0]                                            len; \
    logic [cord_width_mp-1:0]                                           dest_cord; \
  } bsg_vcache_wh_mem_hdr_s

package bsg_manycore_vcache_wh_mem_pkg;

  typedef enum logic [2:0] {
    e_recv_hdr  = 3'd0,
    e_recv_addr = 3'd1,
    e_write     = 3'd2,
    e_read      = 3'd3,
    e_send_hdr  = 3'd4
  } e_wh_mem_state_t;

  localparam int c_max_outstanding_reads = 2;

endpackage

`default_nettype wire

// File: rtl/bsg_manycore_vcache_wh_mem_endpoint.sv
`default_nettype none
// ======================================================================
// Module : bsg_manycore_vcache_wh_mem_endpoint
// Terminates vcache DMA wormhole packets against a word-wide memory port.
// Rev    : 1.0
// ======================================================================
module bsg_manycore_vcache_wh_mem_endpoint
  import bsg_manycore_vcache_wh_mem_pkg::*;
  #(parameter int wh_flit_width_p  = 32
  , parameter int wh_cord_width_p  = 7
  , parameter int wh_len_width_p   = 4
  , parameter int wh_cid_width_p   = 5
  , parameter int mem_addr_width_p = 28
  , parameter int burst_len_p      = 8
  , parameter int my_cord_p        = 0
  )
  (input  logic                        clk_i
  , input  logic                        reset_i
  , input  logic [wh_flit_width_p+1:0]  wh_link_sif_i
  , output logic [wh_flit_width_p+1:0]  wh_link_sif_o
  , output logic                        mem_v_o
  , output logic                        mem_w_o
  , output logic [mem_addr_width_p-1:0] mem_addr_o
  , output logic [wh_flit_width_p-1:0]  mem_data_o
  , input  logic                        mem_ready_i
  , input  logic                        mem_data_v_i
  , input  logic [wh_flit_width_p-1:0]  mem_data_i
  , output logic                        mem_data_yumi_o
  );

  `DECLARE_BSG_VCACHE_WH_MEM_HDR_S(wh_flit_width_p, wh_cord_width_p, wh_len_width_p, wh_cid_width_p);

  localparam int c_cnt_width  = $clog2(burst_len_p+1);
  localparam int c_flit_bytes = wh_flit_width_p/8;

  typedef logic [c_cnt_width-1:0]      cnt_t;
  typedef logic [mem_addr_width_p-1:0] addr_t;

  logic                        w_in_v, w_out_ready, w_in_ready, w_out_v;
  logic [wh_flit_width_p-1:0]  w_in_data, w_out_data;
  bsg_vcache_wh_mem_hdr_s      w_hdr_in, w_resp_hdr;
  logic                        w_unused;

  e_wh_mem_state_t             state_q;
  logic [wh_cord_width_p-1:0]  src_q;
  logic [wh_cid_width_p-1:0]   cid_q;
  logic                        wnr_q;
  addr_t                       addr_q;
  cnt_t                        req_cnt_q, resp_cnt_q;

  cnt_t                        w_outstanding_raw, w_outstanding;
  logic                        w_req_avail;

  assign w_in_v      = wh_link_sif_i[wh_flit_width_p+1];
  assign w_out_ready = wh_link_sif_i[wh_flit_width_p];
  assign w_in_data   = wh_link_sif_i[wh_flit_width_p-1:0];
  assign w_hdr_in    = bsg_vcache_wh_mem_hdr_s'(w_in_data);

  assign wh_link_sif_o = {w_out_v, w_in_ready, w_out_data};

  // The incoming dest/len fields are implied by the link and the packet type.
  assign w_unused = ^{w_hdr_in.pad, w_hdr_in.dest_cord, w_hdr_in.len};

  if (mem_addr_width_p < wh_flit_width_p) begin : g_addr_hi_sink
    logic unused_addr_hi;
    assign unused_addr_hi = ^w_in_data[wh_flit_width_p-1:mem_addr_width_p];
  end

  always_comb begin
    w_resp_hdr                = '0;
    w_resp_hdr.dest_cord      = src_q;
    w_resp_hdr.len            = wh_len_width_p'(burst_len_p);
    w_resp_hdr.cid            = cid_q;
    w_resp_hdr.write_not_read = 1'b0;
    w_resp_hdr.src_cord       = wh_cord_width_p'(my_cord_p);
  end

  // In-flight reads are capped so the memory needs at most two response slots.
  assign w_outstanding_raw = req_cnt_q - resp_cnt_q;
  assign w_outstanding     = (w_outstanding_raw > cnt_t'(c_max_outstanding_reads))
                           ? cnt_t'(c_max_outstanding_reads) : w_outstanding_raw;
  assign w_req_avail       = (req_cnt_q < cnt_t'(burst_len_p))
                           && (w_outstanding < cnt_t'(c_max_outstanding_reads));

  assign mem_addr_o = addr_q + addr_t'(req_cnt_q) * addr_t'(c_flit_bytes);
  assign mem_data_o = w_in_data;

  always_comb begin
    w_in_ready      = 1'b0;
    w_out_v         = 1'b0;
    w_out_data      = '0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_data_yumi_o = 1'b0;
    unique case (state_q)
      e_recv_hdr, e_recv_addr: w_in_ready = 1'b1;
      e_write: begin
        w_in_ready = mem_ready_i;
        mem_v_o    = w_in_v;
        mem_w_o    = 1'b1;
      end
      e_send_hdr: begin
        w_out_v    = 1'b1;
        w_out_data = w_resp_hdr;
      end
      e_read: begin
        w_out_v         = mem_data_v_i;
        w_out_data      = mem_data_i;
        mem_v_o         = w_req_avail;
        mem_data_yumi_o = mem_data_v_i & w_out_ready;
      end
      default: ;
    endcase
    if (reset_i) begin
      w_in_ready      = 1'b0;
      w_out_v         = 1'b0;
      mem_v_o         = 1'b0;
      mem_data_yumi_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_recv_hdr;
      src_q      <= '0;
      cid_q      <= '0;
      wnr_q      <= 1'b0;
      addr_q     <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
    end
    else begin
      unique case (state_q)
        e_recv_hdr: if (w_in_v) begin
          src_q   <= w_hdr_in.src_cord;
          cid_q   <= w_hdr_in.cid;
          wnr_q   <= w_hdr_in.write_not_read;
          state_q <= e_recv_addr;
        end
        e_recv_addr: if (w_in_v) begin
          addr_q     <= w_in_data[mem_addr_width_p-1:0];
          req_cnt_q  <= '0;
          resp_cnt_q <= '0;
          state_q    <= wnr_q ? e_write : e_send_hdr;
        end
        e_write: if (w_in_v & mem_ready_i) begin
          req_cnt_q <= req_cnt_q + cnt_t'(1);
          if (req_cnt_q == cnt_t'(burst_len_p-1))
            state_q <= e_recv_hdr;
        end
        e_send_hdr: if (w_out_ready) state_q <= e_read;
        e_read: begin
          if (mem_v_o & mem_ready_i)
            req_cnt_q <= req_cnt_q + cnt_t'(1);
          if (mem_data_yumi_o) begin
            resp_cnt_q <= resp_cnt_q + cnt_t'(1);
            if (resp_cnt_q == cnt_t'(burst_len_p-1))
              state_q <= e_recv_hdr;
          end
        end
        default: state_q <= e_recv_hdr;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!mem_data_v_i || (state_q == e_read));
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_vcache_wh_mem_endpoint.sv
`default_nettype none
// Randomized bench for the vcache wormhole memory endpoint with a
// packet-level reference model and a behavioural two-slot memory.
module tb_bsg_manycore_vcache_wh_mem_endpoint;

  localparam int W = 32, CW = 7, LW = 4, CIDW = 5, AW = 28, B = 8, MY = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_v, out_ready, in_ready, out_v;
  logic [W-1:0]  in_data, out_data;
  logic [W+1:0]  link_i, link_o;
  logic          mem_v, mem_w, mem_ready, mem_dv, mem_yumi;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  assign link_i   = {in_v, out_ready, in_data};
  assign out_v    = link_o[W+1];
  assign in_ready = link_o[W];
  assign out_data = link_o[W-1:0];

  bsg_manycore_vcache_wh_mem_endpoint #(
    .wh_flit_width_p(W), .wh_cord_width_p(CW), .wh_len_width_p(LW),
    .wh_cid_width_p(CIDW), .mem_addr_width_p(AW), .burst_len_p(B), .my_cord_p(MY)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .wh_link_sif_i(link_i), .wh_link_sif_o(link_o),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_data_v_i(mem_dv), .mem_data_i(mem_rdata),
    .mem_data_yumi_o(mem_yumi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  tx_q[$], rx_q[$], exp_rx[$], pend_q[$];
  logic [AW-1:0] rd_log[$], exp_rd[$], wr_addr_log[$], exp_wr_addr[$];
  logic [W-1:0]  wr_data_log[$], exp_wr_data[$];
  logic [W-1:0]  dev_mem [logic [AW-1:0]];
  logic [W-1:0]  ref_mem [logic [AW-1:0]];

  int in_v_pct = 100, out_rdy_pct = 100, mem_rdy_pct = 100, dv_pct = 100;
  int out_block = 0, mem_block = 0, max_pend = 0;
  bit rst_req = 1'b1, out_blk_now, mem_blk_now;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] fill(input logic [AW-1:0] a);
    return {4'hC, a} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [W-1:0] hdr_word(input int dest, input int len, input int cid,
                                            input int wnr, input int src);
    return W'(dest + (len << CW) + (cid << (CW+LW)) + (wnr << (CW+LW+CIDW))
              + (src << (CW+LW+CIDW+1)));
  endfunction

  task automatic preload(input logic [AW-1:0] addr, input logic [W-1:0] base);
    for (int i = 0; i < B; i++) begin
      dev_mem[addr + AW'(4*i)] = base + W'(i);
      ref_mem[addr + AW'(4*i)] = base + W'(i);
    end
  endtask

  task automatic send_read(input int src, input int cid, input logic [AW-1:0] addr);
    logic [3:0]    junk;
    logic [AW-1:0] a;
    junk = 4'($urandom);
    tx_q.push_back(hdr_word($urandom_range(127), 1, cid, 0, src));
    tx_q.push_back({junk, addr});
    exp_rx.push_back(hdr_word(src, B, cid, 0, MY));
    for (int i = 0; i < B; i++) begin
      a = addr + AW'(4*i);
      exp_rd.push_back(a);
      exp_rx.push_back(ref_mem.exists(a) ? ref_mem[a] : fill(a));
    end
  endtask

  task automatic send_write(input int src, input int cid, input logic [AW-1:0] addr,
                            input logic [W-1:0] base, input bit rnd);
    logic [3:0]    junk;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    junk = 4'($urandom);
    tx_q.push_back(hdr_word($urandom_range(127), B+1, cid, 1, src));
    tx_q.push_back({junk, addr});
    for (int i = 0; i < B; i++) begin
      a = addr + AW'(4*i);
      d = rnd ? W'($urandom) : base + W'(i);
      tx_q.push_back(d);
      exp_wr_addr.push_back(a);
      exp_wr_data.push_back(d);
      ref_mem[a] = d;
    end
  endtask

  task automatic clear_all();
    tx_q.delete(); rx_q.delete(); exp_rx.delete();
    rd_log.delete(); exp_rd.delete();
    wr_addr_log.delete(); wr_data_log.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
    max_pend = 0;
  endtask

  // ---------------- one clock of link sender, sink and memory ----------------
  task automatic cycle();
    logic [W-1:0] new_rd;
    bit           push_rd;
    @(negedge clk);
    reset = rst_req;
    if (rst_req) pend_q.delete();
    out_blk_now = (out_block > 0);
    mem_blk_now = (mem_block > 0);
    in_v      = (tx_q.size() > 0) && ($urandom_range(99) < in_v_pct);
    in_data   = (tx_q.size() > 0) ? tx_q[0] : W'($urandom);
    out_ready = out_blk_now ? 1'b0 : ($urandom_range(99) < out_rdy_pct);
    mem_ready = mem_blk_now ? 1'b0 : ($urandom_range(99) < mem_rdy_pct);
    mem_dv    = (pend_q.size() > 0) && ($urandom_range(99) < dv_pct);
    mem_rdata = (pend_q.size() > 0) ? pend_q[0] : W'($urandom);
    #1;
    push_rd = 1'b0;
    new_rd  = '0;
    if (in_v && in_ready) void'(tx_q.pop_front());
    if (mem_v && mem_ready) begin
      if (mem_w) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
        dev_mem[mem_addr] = mem_wdata;
      end else begin
        rd_log.push_back(mem_addr);
        new_rd  = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : fill(mem_addr);
        push_rd = 1'b1;
      end
    end
    if (mem_yumi && pend_q.size() > 0) void'(pend_q.pop_front());
    if (out_v && out_ready) rx_q.push_back(out_data);
    if (push_rd) pend_q.push_back(new_rd);
    if (pend_q.size() > max_pend) max_pend = pend_q.size();
    if (out_block > 0) out_block--;
    if (mem_block > 0) mem_block--;
  endtask

  task automatic run_until(input int n_rx, input int n_wr, input int budget, output int used);
    used = 0;
    while ((rx_q.size() < n_rx || wr_addr_log.size() < n_wr || tx_q.size() != 0
            || pend_q.size() != 0) && used < budget) begin
      cycle();
      used++;
    end
    repeat (4) cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_req = 1'b1;
    cycle(); cycle();
    n_checks++;
    if ({in_ready, out_v, mem_v, mem_yumi} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready/v/mem_v/yumi=%b required 0000",
               {in_ready, out_v, mem_v, mem_yumi});
    end
    rst_req = 1'b0;
    cycle();
    n_checks++;
    if ({in_ready, out_v, mem_v, mem_yumi} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got ready/v/mem_v/yumi=%b required 1000",
               {in_ready, out_v, mem_v, mem_yumi});
    end
  endtask

  task automatic test_read();
    int used;
    clear_all();
    preload(28'h1000, 32'hA0);
    send_read(3, 5, 28'h1000);
    run_until(B+1, 0, 500, used);
    n_checks++;
    if (used >= 500) begin n_fail++; $display("FAIL read_timeout: got %0d cycles limit 500", used); end
    n_checks++;
    if (rx_q.size() !== B+1) begin n_fail++; $display("FAIL read_rx_count: got %0d required %0d", rx_q.size(), B+1); end
    n_checks++;
    if (rx_q.size() > 0 && rx_q[0] !== 32'h0000_2C03) begin
      n_fail++; $display("FAIL read_hdr_literal: got %h required 00002c03", rx_q[0]);
    end
    foreach (exp_rx[i]) if (i < rx_q.size()) begin
      n_checks++;
      if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL read_flit[%0d]: got %h required %h", i, rx_q[i], exp_rx[i]); end
    end
    foreach (exp_rd[i]) if (i < rd_log.size()) begin
      n_checks++;
      if (rd_log[i] !== exp_rd[i]) begin n_fail++; $display("FAIL read_addr[%0d]: got %h required %h", i, rd_log[i], exp_rd[i]); end
    end
    n_checks++;
    if (rd_log.size() !== B || wr_addr_log.size() !== 0) begin
      n_fail++; $display("FAIL read_mem_ops: got %0d reads %0d writes required %0d/0", rd_log.size(), wr_addr_log.size(), B);
    end
  endtask

  task automatic test_write();
    int used;
    clear_all();
    send_write(2, 9, 28'h2000, 32'hB0, 1'b0);
    run_until(0, B, 500, used);
    n_checks++;
    if (used >= 500) begin n_fail++; $display("FAIL write_timeout: got %0d cycles limit 500", used); end
    n_checks++;
    if (wr_addr_log.size() !== B) begin n_fail++; $display("FAIL write_count: got %0d required %0d", wr_addr_log.size(), B); end
    foreach (exp_wr_addr[i]) if (i < wr_addr_log.size()) begin
      n_checks++;
      if (wr_addr_log[i] !== exp_wr_addr[i] || wr_data_log[i] !== exp_wr_data[i]) begin
        n_fail++; $display("FAIL write_beat[%0d]: got %h/%h required %h/%h", i,
                           wr_addr_log[i], wr_data_log[i], exp_wr_addr[i], exp_wr_data[i]);
      end
    end
    n_checks++;
    if (rx_q.size() !== 0) begin n_fail++; $display("FAIL write_no_response: got %0d flits required 0", rx_q.size()); end
  endtask

  task automatic test_backpressure();
    int  c = 0;
    bit  trig = 1'b0;
    clear_all();
    send_read(6, 17, 28'h0ABC0);
    while ((rx_q.size() < B+1 || pend_q.size() != 0) && c < 500) begin
      if (!trig && rx_q.size() == 4) begin out_block = 5; trig = 1'b1; end
      cycle();
      c++;
      if (out_blk_now) begin
        n_checks++;
        if (mem_yumi !== 1'b0) begin n_fail++; $display("FAIL bp_yumi_while_blocked: got %b required 0", mem_yumi); end
      end
    end
    repeat (4) cycle();
    n_checks++;
    if (c >= 500) begin n_fail++; $display("FAIL bp_timeout: got %0d cycles limit 500", c); end
    n_checks++;
    if (rx_q.size() !== B+1) begin n_fail++; $display("FAIL bp_rx_count: got %0d required %0d", rx_q.size(), B+1); end
    foreach (exp_rx[i]) if (i < rx_q.size()) begin
      n_checks++;
      if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL bp_flit[%0d]: got %h required %h", i, rx_q[i], exp_rx[i]); end
    end
    n_checks++;
    if (max_pend > 2 || max_pend < 1) begin n_fail++; $display("FAIL bp_outstanding: got %0d required 1..2", max_pend); end
  endtask

  task automatic test_mem_stall();
    int c = 0, stalls = 0;
    bit trig = 1'b0;
    clear_all();
    send_write(1, 2, 28'h3000, 32'hC0DE_0000, 1'b0);
    while (wr_addr_log.size() < B && c < 500) begin
      if (!trig && wr_addr_log.size() == 2) begin mem_block = 3; trig = 1'b1; end
      cycle();
      c++;
      if (mem_blk_now) begin
        stalls++;
        n_checks++;
        if (in_ready !== 1'b0 || mem_v !== 1'b1 || mem_wdata !== 32'hC0DE_0002
            || mem_addr !== 28'h3008) begin
          n_fail++;
          $display("FAIL stall_hold: got rdy=%b v=%b addr=%h data=%h required 0/1/3008/c0de0002",
                   in_ready, mem_v, mem_addr, mem_wdata);
        end
      end
    end
    repeat (4) cycle();
    n_checks++;
    if (stalls !== 3 || c >= 500) begin n_fail++; $display("FAIL stall_cycles: got %0d (c=%0d) required 3", stalls, c); end
    foreach (exp_wr_addr[i]) if (i < wr_addr_log.size()) begin
      n_checks++;
      if (wr_addr_log[i] !== exp_wr_addr[i] || wr_data_log[i] !== exp_wr_data[i]) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got %h/%h required %h/%h", i,
                           wr_addr_log[i], wr_data_log[i], exp_wr_addr[i], exp_wr_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c = 0, wr_at_rx = -1;
    clear_all();
    send_write(4, 8, 28'h4000, 32'h0, 1'b1);
    send_read(4, 8, 28'h4000);
    while ((rx_q.size() < B+1 || tx_q.size() != 0 || pend_q.size() != 0) && c < 800) begin
      cycle();
      c++;
      if (wr_at_rx < 0 && rx_q.size() > 0) wr_at_rx = wr_addr_log.size();
    end
    repeat (4) cycle();
    n_checks++;
    if (c >= 800) begin n_fail++; $display("FAIL b2b_timeout: got %0d cycles limit 800", c); end
    n_checks++;
    if (wr_at_rx !== B) begin n_fail++; $display("FAIL b2b_order: got %0d writes before response required %0d", wr_at_rx, B); end
    n_checks++;
    if (rx_q.size() !== B+1 || rd_log.size() !== B) begin
      n_fail++; $display("FAIL b2b_counts: got rx=%0d rd=%0d required %0d/%0d", rx_q.size(), rd_log.size(), B+1, B);
    end
    foreach (exp_rx[i]) if (i < rx_q.size()) begin
      n_checks++;
      if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL b2b_flit[%0d]: got %h required %h", i, rx_q[i], exp_rx[i]); end
    end
    foreach (exp_rd[i]) if (i < rd_log.size()) begin
      n_checks++;
      if (rd_log[i] !== exp_rd[i]) begin n_fail++; $display("FAIL b2b_rd_addr[%0d]: got %h required %h", i, rd_log[i], exp_rd[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0, used;
    clear_all();
    send_read(9, 3, 28'h5000);
    while (rx_q.size() < 4 && c < 500) begin cycle(); c++; end
    n_checks++;
    if (c >= 500) begin n_fail++; $display("FAIL rmid_first_timeout: got %0d cycles limit 500", c); end
    rst_req = 1'b1;
    cycle();
    n_checks++;
    if ({in_ready, out_v, mem_v, mem_yumi} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_reset_outputs: got %b required 0000", {in_ready, out_v, mem_v, mem_yumi});
    end
    rst_req = 1'b0;
    clear_all();
    preload(28'h6000, 32'hD0);
    send_read(11, 30, 28'h6000);
    run_until(B+1, 0, 500, used);
    n_checks++;
    if (used >= 500) begin n_fail++; $display("FAIL rmid_timeout: got %0d cycles limit 500", used); end
    n_checks++;
    if (rx_q.size() !== B+1) begin n_fail++; $display("FAIL rmid_rx_count: got %0d required %0d", rx_q.size(), B+1); end
    foreach (exp_rx[i]) if (i < rx_q.size()) begin
      n_checks++;
      if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL rmid_flit[%0d]: got %h required %h", i, rx_q[i], exp_rx[i]); end
    end
  endtask

  task automatic test_random();
    int            used, n_rx = 0;
    logic [AW-1:0] a, last_wr;
    clear_all();
    last_wr = 28'h0010;
    for (int p = 0; p < 14; p++) begin
      in_v_pct    = $urandom_range(100, 50);
      out_rdy_pct = $urandom_range(100, 30);
      mem_rdy_pct = $urandom_range(100, 30);
      dv_pct      = $urandom_range(100, 30);
      a = AW'($urandom) & ~AW'(3);
      if (p == 3) a = 28'hFFF_FFF0;
      if ($urandom_range(1) == 1) begin
        send_write($urandom_range(127), $urandom_range(31), a, '0, 1'b1);
        last_wr = a;
      end else begin
        if ($urandom_range(1) == 1) a = last_wr;
        send_read($urandom_range(127), $urandom_range(31), a);
        n_rx += B + 1;
      end
      run_until(n_rx, exp_wr_addr.size(), 2000, used);
      n_checks++;
      if (used >= 2000) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %0d cycles limit 2000", p, used); end
    end
    in_v_pct = 100; out_rdy_pct = 100; mem_rdy_pct = 100; dv_pct = 100;
    n_checks++;
    if (rx_q.size() !== exp_rx.size() || rd_log.size() !== exp_rd.size()
        || wr_addr_log.size() !== exp_wr_addr.size()) begin
      n_fail++; $display("FAIL rand_counts: got rx=%0d rd=%0d wr=%0d required %0d/%0d/%0d",
                         rx_q.size(), rd_log.size(), wr_addr_log.size(),
                         exp_rx.size(), exp_rd.size(), exp_wr_addr.size());
    end
    foreach (exp_rx[i]) if (i < rx_q.size()) begin
      n_checks++;
      if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL rand_flit[%0d]: got %h required %h", i, rx_q[i], exp_rx[i]); end
    end
    foreach (exp_rd[i]) if (i < rd_log.size()) begin
      n_checks++;
      if (rd_log[i] !== exp_rd[i]) begin n_fail++; $display("FAIL rand_rd_addr[%0d]: got %h required %h", i, rd_log[i], exp_rd[i]); end
    end
    foreach (exp_wr_addr[i]) if (i < wr_addr_log.size()) begin
      n_checks++;
      if (wr_addr_log[i] !== exp_wr_addr[i] || wr_data_log[i] !== exp_wr_data[i]) begin
        n_fail++; $display("FAIL rand_wr[%0d]: got %h/%h required %h/%h", i,
                           wr_addr_log[i], wr_data_log[i], exp_wr_addr[i], exp_wr_data[i]);
      end
    end
    n_checks++;
    if (max_pend > 2) begin n_fail++; $display("FAIL rand_outstanding: got %0d required <=2", max_pend); end
  endtask

  initial begin
    reset = 1'b1; in_v = 1'b0; in_data = '0; out_ready = 1'b0;
    mem_ready = 1'b0; mem_dv = 1'b0; mem_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_mem_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
